// File: rtl/frame_dump_pkg.sv
// Shared definitions for the thumbnail dump sequencer: state encoding,
// sync header bytes and the shadow-word byte selector.
package frame_dump_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FRAME,
      HEADER,
      FETCH,
      SEND,
      ADVANCE,
      DONE
   } state_t;

   localparam logic [7:0] HDR_BYTE0 = 8'hA5;
   localparam logic [7:0] HDR_BYTE1 = 8'h5A;

   // Byte 0 is the most significant byte of the buffer word.
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] z);
      logic [7:0] b;
      case (z)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tx_pacer.sv
// UART pacing: counts idle cycles since the last busy/strobe cycle and
// reports when another byte may be written.
module tx_pacer #(
   parameter int HOLDOFF = 8191
) (
   input  logic clk12,
   input  logic areset_n,
   input  logic tx_busy,
   input  logic tx_wr,
   output logic ready
);

   localparam int HC_W = $clog2(HOLDOFF + 1);
   localparam logic [HC_W-1:0] HC_MAX = HC_W'(HOLDOFF);

   logic [HC_W-1:0] hc;

   always_ff @(posedge clk12 or negedge areset_n) begin
      if (!areset_n)
         hc <= '0;
      else if (tx_busy || tx_wr)
         hc <= '0;
      else if (hc != HC_MAX)
         hc <= hc + 1'b1;
   end

   assign ready = (hc == HC_MAX) && !tx_busy && !tx_wr;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Frame-aligned thumbnail dump: freezes the downsample buffer, walks it
// row by row and streams each 32-bit word MSB-first to the debug UART.
module frame_dump_ctrl
   import frame_dump_pkg::*;
#(
   parameter int COLS    = 40,
   parameter int ROWS    = 30,
   parameter int X_W     = 6,
   parameter int Y_W     = 5,
   parameter int RD_LAT  = 1,
   parameter int HOLDOFF = 8191,
   parameter int HDR_EN  = 1
) (
   input  logic           clk12,
   input  logic           areset_n,
   input  logic           trigger,
   input  logic           abort,
   input  logic           frame_sync,
   output logic           freeze,
   output logic [X_W-1:0] read_x,
   output logic [Y_W-1:0] read_y,
   input  logic [31:0]    read_q,
   output logic [7:0]     tx_data,
   output logic           tx_wr,
   input  logic           tx_busy,
   output logic           busy,
   output logic           done
);

   localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);
   localparam logic [1:0]     LAT    = 2'(RD_LAT);

   state_t      state;
   logic [1:0]  z;
   logic [1:0]  lat;
   logic [31:0] shadow;
   logic        ready;

   tx_pacer #(.HOLDOFF(HOLDOFF)) u_pacer (
      .clk12    (clk12),
      .areset_n (areset_n),
      .tx_busy  (tx_busy),
      .tx_wr    (tx_wr),
      .ready    (ready)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk12 or negedge areset_n) begin
      if (!areset_n) begin
         state   <= IDLE;
         freeze  <= 1'b0;
         read_x  <= '0;
         read_y  <= '0;
         tx_data <= '0;
         tx_wr   <= 1'b0;
         done    <= 1'b0;
         z       <= '0;
         lat     <= '0;
         shadow  <= '0;
      end else begin
         tx_wr <= 1'b0;
         done  <= 1'b0;
         // Abort outranks everything once a dump is armed, including frame_sync.
         if (abort && state != IDLE) begin
            state  <= IDLE;
            freeze <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (trigger)
                     state <= WAIT_FRAME;
               end
               WAIT_FRAME: begin
                  if (frame_sync) begin
                     freeze <= 1'b1;
                     read_x <= '0;
                     read_y <= '0;
                     z      <= '0;
                     lat    <= '0;
                     state  <= (HDR_EN != 0) ? HEADER : FETCH;
                  end
               end
               HEADER: begin
                  if (ready) begin
                     tx_data <= z[0] ? HDR_BYTE1 : HDR_BYTE0;
                     tx_wr   <= 1'b1;
                     if (z[0]) begin
                        z     <= '0;
                        lat   <= '0;
                        state <= FETCH;
                     end else begin
                        z <= z + 1'b1;
                     end
                  end
               end
               FETCH: begin
                  // Address has been stable since entry; read_q settles RD_LAT cycles later.
                  if (lat == LAT) begin
                     shadow <= read_q;
                     z      <= '0;
                     state  <= SEND;
                  end else begin
                     lat <= lat + 1'b1;
                  end
               end
               SEND: begin
                  if (ready) begin
                     tx_data <= word_byte(shadow, z);
                     tx_wr   <= 1'b1;
                     z       <= z + 1'b1;
                     if (z == 2'd3)
                        state <= ADVANCE;
                  end
               end
               ADVANCE: begin
                  lat <= '0;
                  if (read_x == X_LAST && read_y == Y_LAST) begin
                     state <= DONE;
                  end else if (read_x == X_LAST) begin
                     read_x <= '0;
                     read_y <= read_y + 1'b1;
                     state  <= FETCH;
                  end else begin
                     read_x <= read_x + 1'b1;
                     state  <= FETCH;
                  end
               end
               DONE: begin
                  done   <= 1'b1;
                  freeze <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: control-path vector table, full dumps against a
// byte-stream model, abort, read-latency and asynchronous reset sequences.
module tb_frame_dump_ctrl;

   localparam int COLS    = 6;
   localparam int ROWS    = 4;
   localparam int X_W     = 6;
   localparam int Y_W     = 5;
   localparam int RD_LAT  = 3;
   localparam int HOLDOFF = 16;
   localparam int HDR_EN  = 1;
   localparam int NBYTES  = 2 * HDR_EN + 4 * COLS * ROWS;

   logic           clk12      = 1'b0;
   logic           areset_n   = 1'b0;
   logic           trigger    = 1'b0;
   logic           abort      = 1'b0;
   logic           frame_sync = 1'b0;
   logic           tx_busy    = 1'b0;
   logic           freeze, tx_wr, busy, done;
   logic [X_W-1:0] read_x;
   logic [Y_W-1:0] read_y;
   logic [31:0]    read_q;
   logic [7:0]     tx_data;

   always #5 clk12 = ~clk12;

   frame_dump_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W),
      .RD_LAT(RD_LAT), .HOLDOFF(HOLDOFF), .HDR_EN(HDR_EN)
   ) dut (
      .clk12(clk12), .areset_n(areset_n), .trigger(trigger), .abort(abort),
      .frame_sync(frame_sync), .freeze(freeze), .read_x(read_x), .read_y(read_y),
      .read_q(read_q), .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
      .busy(busy), .done(done)
   );

   // Buffer contents as a function of location.
   function automatic logic [31:0] mem_word(input int x, input int y);
      logic [7:0] xb, yb;
      xb = 8'(x);
      yb = 8'(y);
      return {yb, xb, 8'(x * 7 + y), xb ^ (yb << 3) ^ 8'h5A};
   endfunction

   // Buffer read port: data reflects the address RD_LAT cycles back.
   logic [2:0][X_W+Y_W-1:0] hist;
   always @(posedge clk12) hist <= {hist[1:0], read_y, read_x};
   assign read_q = mem_word(int'(hist[RD_LAT-1][X_W-1:0]), int'(hist[RD_LAT-1][X_W+Y_W-1:X_W]));

   typedef struct {
      logic [7:0] data;
      int         gap;
      logic       busy_at;
      logic       b2b;
      logic       frz;
   } wr_rec_t;

   wr_rec_t rx[$];
   int      tot_wr    = 0;
   int      tot_done  = 0;
   int      cyc       = 0;
   int      last_busy = 0;
   int      bcnt      = 0;
   logic    prev_wr   = 1'b0;

   // UART model plus strobe recorder.
   always @(negedge clk12) begin
      cyc <= cyc + 1;
      if (tx_wr) begin
         rx.push_back(wr_rec_t'{tx_data, cyc - last_busy, tx_busy, prev_wr, freeze});
         tot_wr <= tot_wr + 1;
      end
      if (done) tot_done <= tot_done + 1;
      if (tx_busy || tx_wr) last_busy <= cyc;
      prev_wr <= tx_wr;
      if (tx_wr) begin
         tx_busy <= 1'b1;
         bcnt    <= int'($urandom_range(1, 12));
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else if (bcnt == 1) begin
         bcnt    <= 0;
         tx_busy <= 1'b0;
      end
   end

   typedef struct {
      logic trig, ab, fs, e_busy, e_frz;
   } vec_t;

   vec_t       tbl[13];
   logic [7:0] exp_q[$];
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk12);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " freeze"}, freeze, 0);
      chk({tag, " read_x"}, read_x, 0);
      chk({tag, " read_y"}, read_y, 0);
      chk({tag, " tx_data"}, tx_data, 0);
      chk({tag, " tx_wr"}, tx_wr, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
   endtask

   task automatic check_bytes(input int base, input int n, input string tag);
      for (int i = 0; i < n && base + i < rx.size(); i++) begin
         chk($sformatf("%s byte%0d data", tag, i), rx[base+i].data, exp_q[i]);
         chk($sformatf("%s byte%0d holdoff", tag, i), rx[base+i].gap > HOLDOFF, 1);
         chk($sformatf("%s byte%0d wr_while_busy", tag, i), rx[base+i].busy_at, 0);
         chk($sformatf("%s byte%0d back_to_back", tag, i), rx[base+i].b2b, 0);
         chk($sformatf("%s byte%0d freeze", tag, i), rx[base+i].frz, 1);
      end
   endtask

   task automatic start_dump();
      trigger = 1'b1; tick(); trigger = 1'b0;
      tick(100);
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
   endtask

   task automatic wait_bytes(input int base, input int n, input string tag);
      int k = 0;
      while (tot_wr - base < n && k < 20000) begin tick(); k++; end
      chk({tag, " reached byte target"}, tot_wr - base >= n, 1);
   endtask

   task automatic run_dump(input bit disturb, input string tag);
      int base, dbase, k, frz_bad;
      base = tot_wr; dbase = tot_done; k = 0; frz_bad = 0;
      start_dump();
      chk({tag, " freeze after frame_sync"}, freeze, 1);
      while (!done && k < 20000) begin
         if (disturb) begin
            trigger    = ($urandom_range(0, 30) == 0);
            frame_sync = ($urandom_range(0, 30) == 0);
         end
         tick(); k++;
         if (!done && !freeze) frz_bad++;
      end
      trigger = 1'b0; frame_sync = 1'b0;
      chk({tag, " done within budget"}, done, 1);
      tick(3);
      chk({tag, " done pulses"}, tot_done - dbase, 1);
      chk({tag, " freeze drop cycles"}, frz_bad, 0);
      chk({tag, " busy after"}, busy, 0);
      chk({tag, " freeze after"}, freeze, 0);
      chk({tag, " byte count"}, tot_wr - base, NBYTES);
      check_bytes(base, NBYTES, tag);
   endtask

   initial begin
      int base, dbase;
      //        trig ab fs busy frz
      tbl[0]  = '{0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 0, 0};  // frame_sync in IDLE
      tbl[2]  = '{0, 1, 0, 0, 0};  // abort in IDLE
      tbl[3]  = '{1, 1, 0, 1, 0};  // trigger beats abort
      tbl[4]  = '{0, 1, 1, 0, 0};  // abort beats frame_sync
      tbl[5]  = '{1, 0, 0, 1, 0};
      tbl[6]  = '{0, 0, 1, 1, 1};
      tbl[7]  = '{1, 0, 0, 1, 1};  // trigger while busy
      tbl[8]  = '{0, 0, 1, 1, 1};  // frame_sync outside WAIT_FRAME
      tbl[9]  = '{0, 1, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 0, 0};
      tbl[11] = '{1, 0, 0, 1, 0};
      tbl[12] = '{0, 1, 0, 0, 0};  // abort in WAIT_FRAME

      if (HDR_EN != 0) begin exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); end
      for (int y = 0; y < ROWS; y++)
         for (int x = 0; x < COLS; x++) begin
            logic [31:0] w;
            w = mem_word(x, y);
            exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
         end

      tick(3);
      chk_reset_outputs("reset");
      areset_n = 1'b1;
      tick(2);
      chk("after release busy", busy, 0);

      for (int i = 0; i < 13; i++) begin
         trigger = tbl[i].trig; abort = tbl[i].ab; frame_sync = tbl[i].fs;
         tick();
         trigger = 1'b0; abort = 1'b0; frame_sync = 1'b0;
         chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
         chk($sformatf("vec%0d freeze", i), freeze, tbl[i].e_frz);
         chk($sformatf("vec%0d done", i), done, 0);
      end
      tick(20);

      run_dump(1'b0, "dump1");
      run_dump(1'b1, "dump_disturbed");

      // Abort part-way through the pixel stream.
      base = tot_wr; dbase = tot_done;
      start_dump();
      wait_bytes(base, 40, "abort");
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort freeze", freeze, 0);
      tick(300);
      chk("abort byte count", tot_wr - base, 40);
      chk("abort no done", tot_done - dbase, 0);
      check_bytes(base, 40, "abort");
      run_dump(1'b0, "restart");

      // Asynchronous reset mid-dump, away from any clock edge.
      base = tot_wr;
      start_dump();
      wait_bytes(base, 31, "areset");
      #3;
      areset_n = 1'b0;
      #1;
      chk_reset_outputs("async reset");
      tick(3);
      areset_n = 1'b1;
      tick(2);
      chk("post reset busy", busy, 0);
      run_dump(1'b0, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
